// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter (bus responder).
// A small TX FIFO feeds a bit-timed shifter; TxD idles high and frames go out LSB first.
// IRQ flags "transmitter drained": FIFO empty and shifter idle.
module uart_tx_dev #(
    parameter int                   FIFO_DEPTH = 8,
    parameter int                   DIV_WIDTH  = 16,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        TxD
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Register file and FIFO state
    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 tx_en;
    logic                 irq_en;
    logic [DIV_WIDTH-1:0] div_reg;

    // Transmitter state
    state_t               state;
    state_t               state_nx;
    logic [DIV_WIDTH-1:0] timer;
    logic [DIV_WIDTH-1:0] timer_nx;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [DIV_WIDTH-1:0] div_lat_nx;
    logic [2:0]           idx;
    logic [2:0]           idx_nx;
    logic [7:0]           shift;
    logic [7:0]           shift_nx;
    logic                 pop;
    logic                 tx_bit;
    logic                 bit_end;
    logic                 busy;

    // Bus decode
    logic                 sel_data;
    logic                 sel_stat;
    logic                 sel_ctrl;
    logic                 sel_div;
    logic                 push;
    logic [3:0]           cnt_field;
    logic                 unused_bits;

    assign sel_data = WE && (Addr[3:2] == 2'd0);
    assign sel_stat = WE && (Addr[3:2] == 2'd1);
    assign sel_ctrl = WE && (Addr[3:2] == 2'd2);
    assign sel_div  = WE && (Addr[3:2] == 2'd3);

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = sel_data && !full;
    assign busy      = (state != S_IDLE);
    assign bit_end   = (timer == div_lat - DIV_WIDTH'(1));
    assign cnt_field = 4'(count);
    assign IRQ       = irq_en && empty && !busy;
    assign TxD       = tx_bit;

    assign unused_bits = ^{Addr[31:4], Din};

    // FIFO storage: written on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= Din[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (sel_data && full) begin
                ovf <= 1'b1;
            end else if (sel_stat) begin
                ovf <= 1'b0;
            end
        end
    end

    // Control and divisor registers; a zero divisor is stored as 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_en   <= 1'b0;
            irq_en  <= 1'b0;
            div_reg <= DIV_RESET;
        end else begin
            if (sel_ctrl) begin
                tx_en  <= Din[0];
                irq_en <= Din[1];
            end
            if (sel_div) begin
                div_reg <= (Din[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1) : Din[DIV_WIDTH-1:0];
            end
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            div_lat <= DIV_WIDTH'(1);
            idx     <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            div_lat <= div_lat_nx;
            idx     <= idx_nx;
            shift   <= shift_nx;
        end
    end

    // Transmitter next-state, FIFO pop and serial output
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        div_lat_nx = div_lat;
        idx_nx     = idx;
        shift_nx   = shift;
        pop        = 1'b0;
        tx_bit     = 1'b1;
        case (state)
            S_IDLE: begin
                if (tx_en && !empty) begin
                    pop        = 1'b1;
                    shift_nx   = mem[rd_ptr];
                    div_lat_nx = div_reg;
                    timer_nx   = '0;
                    state_nx   = S_START;
                end
            end
            S_START: begin
                tx_bit = 1'b0;
                if (bit_end) begin
                    timer_nx = '0;
                    idx_nx   = '0;
                    state_nx = S_DATA;
                end else begin
                    timer_nx = timer + DIV_WIDTH'(1);
                end
            end
            S_DATA: begin
                tx_bit = shift[0];
                if (bit_end) begin
                    timer_nx = '0;
                    shift_nx = {1'b0, shift[7:1]};
                    if (idx == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end else begin
                    timer_nx = timer + DIV_WIDTH'(1);
                end
            end
            S_STOP: begin
                tx_bit = 1'b1;
                if (bit_end) begin
                    timer_nx = '0;
                    state_nx = S_IDLE;
                end else begin
                    timer_nx = timer + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Combinational read mux
    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd0:    Dout = '0;
            2'd1:    Dout = {cnt_field, 24'b0, ovf, busy, empty, full};
            2'd2:    Dout = {30'b0, irq_en, tx_en};
            default: Dout = 32'(div_reg);
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Testbench for uart_tx_dev: randomized bytes/divisors checked against a
// queue-based FIFO model and an ideal 8N1 waveform built from each byte.
module tb_uart_tx_dev;

    localparam int DEPTH = 8;
    localparam logic [31:2] A_DATA = 30'd0;
    localparam logic [31:2] A_STAT = 30'd1;
    localparam logic [31:2] A_CTRL = 30'd2;
    localparam logic [31:2] A_DIV  = 30'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        TxD;

    int n_cmp  = 0;
    int n_fail = 0;

    byte unsigned model_q[$];
    logic         model_ovf;

    uart_tx_dev #(
        .FIFO_DEPTH(DEPTH),
        .DIV_WIDTH (16),
        .DIV_RESET (16'd434)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ),
        .TxD  (TxD)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:2] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:2] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_write(A_DATA, {24'h0, b});
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    function automatic logic [31:0] exp_status(input logic busy);
        logic [31:0] s;
        s        = '0;
        s[31:28] = 4'(model_q.size());
        s[3]     = model_ovf;
        s[2]     = busy;
        s[1]     = (model_q.size() == 0);
        s[0]     = (model_q.size() == DEPTH);
        return s;
    endfunction

    // Steps until TxD goes low (start bit), at most max cycles.
    task automatic wait_start(input int max, input string tag);
        int k;
        k = 0;
        while (TxD !== 1'b0 && k < max) begin
            step(1);
            k++;
        end
        n_cmp++;
        if (TxD !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: TxD=%b required 0 within %0d cycles", tag, TxD, max);
        end
    endtask

    // Called at the first cycle of the start bit; ends on the cycle after stop.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag);
        logic [9:0]  f;
        logic [31:0] st;
        int          irq_hi;
        f      = {1'b1, b, 1'b0};
        irq_hi = 0;
        for (int k = 0; k < 10; k++) begin
            int   bad;
            logic seen;
            bad  = 0;
            seen = f[k];
            for (int c = 0; c < div; c++) begin
                if (TxD !== f[k]) begin
                    bad++;
                    seen = TxD;
                end
                if (IRQ !== 1'b0) irq_hi++;
                step(1);
            end
            n_cmp++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL %s bit%0d byte=%h: TxD=%b required %b on %0d of %0d cycles",
                         tag, k, b, seen, f[k], bad, div);
            end
        end
        n_cmp++;
        if (irq_hi !== 0) begin
            n_fail++;
            $display("FAIL %s irq_during_frame: IRQ high %0d cycles required 0", tag, irq_hi);
        end
        bus_read(A_STAT, st);
        n_cmp++;
        if (st[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after_frame: busy=%b required 0", tag, st[2]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        model_ovf = 1'b0;
        model_q.delete();
        step(3);
        reset = 1'b0;
        step(1);
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_fail++; $display("FAIL reset_status: got %h required %h", d, 32'h2);
        end
        n_cmp++;
        if (TxD !== 1'b1) begin
            n_fail++; $display("FAIL reset_txd: got %b required 1", TxD);
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b required 0", IRQ);
        end
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd434) begin
            n_fail++; $display("FAIL reset_div: got %0d required 434", d);
        end
        bus_read(A_CTRL, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h required 0", d);
        end
        bus_read(A_DATA, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL data_read: got %h required 0", d);
        end
    endtask

    task automatic test_basic_frame();
        bus_write(A_DIV, 32'd4);
        bus_write(A_CTRL, 32'd1);
        push_byte(8'hA5);
        wait_start(5, "basic");
        check_frame(model_q.pop_front(), 4, "basic");
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 5; i++) begin
            int          div;
            logic [7:0]  b;
            div = int'($urandom_range(1, 6));
            b   = 8'($urandom);
            bus_write(A_DIV, 32'(div));
            push_byte(b);
            wait_start(5, "random");
            check_frame(model_q.pop_front(), div, "random");
        end
    endtask

    task automatic test_overflow_back_to_back();
        logic [31:0] d;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_DIV, 32'd1);
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== exp_status(1'b0)) begin
            n_fail++; $display("FAIL ovf_status: got %h required %h", d, exp_status(1'b0));
        end
        bus_write(A_STAT, 32'($urandom));
        model_ovf = 1'b0;
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== exp_status(1'b0)) begin
            n_fail++; $display("FAIL ovf_clear: got %h required %h", d, exp_status(1'b0));
        end
        bus_write(A_CTRL, 32'd1);
        wait_start(3, "b2b_first");
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin
                step(1);
                wait_start(0, "b2b_gap");
            end
            check_frame(model_q.pop_front(), 1, "b2b");
        end
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== exp_status(1'b0)) begin
            n_fail++; $display("FAIL drained_status: got %h required %h", d, exp_status(1'b0));
        end
    endtask

    task automatic test_irq();
        bus_write(A_DIV, 32'd2);
        bus_write(A_CTRL, 32'd3);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_fail++; $display("FAIL irq_idle_empty: got %b required 1", IRQ);
        end
        for (int r = 0; r < 2; r++) begin
            push_byte(8'($urandom));
            n_cmp++;
            if (IRQ !== 1'b0) begin
                n_fail++; $display("FAIL irq_after_push: got %b required 0", IRQ);
            end
            wait_start(5, "irq");
            check_frame(model_q.pop_front(), 2, "irq");
            n_cmp++;
            if (IRQ !== 1'b1) begin
                n_fail++; $display("FAIL irq_after_stop: got %b required 1", IRQ);
            end
        end
        bus_write(A_CTRL, 32'd1);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_fail++; $display("FAIL irq_disable: got %b required 0", IRQ);
        end
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] d;
        logic [7:0]  first;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_DIV, 32'd2);
        push_byte(8'($urandom));
        bus_write(A_CTRL, 32'd1);
        first = model_q.pop_front();
        push_byte(8'($urandom));
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== exp_status(1'b1)) begin
            n_fail++; $display("FAIL simul_status: got %h required %h", d, exp_status(1'b1));
        end
        check_frame(first, 2, "simul1");
        step(1);
        wait_start(0, "simul_gap");
        check_frame(model_q.pop_front(), 2, "simul2");
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd1) begin
            n_fail++; $display("FAIL div_zero: got %0d required 1", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          highs;
        bus_write(A_DIV, 32'd8);
        bus_write(A_CTRL, 32'd1);
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wait_start(10, "rst_mid");
        step(8 + 8 * 2 + 3);
        reset = 1'b1;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        n_cmp++;
        if (TxD !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_txd: got %b required 1", TxD);
        end
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_fail++; $display("FAIL rst_mid_status: got %h required %h", d, 32'h2);
        end
        step(2);
        #2;
        reset = 1'b0;
        step(1);
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd434) begin
            n_fail++; $display("FAIL rst_mid_div: got %0d required 434", d);
        end
        bus_write(A_CTRL, 32'd1);
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            if (TxD === 1'b1) highs++;
            step(1);
        end
        n_cmp++;
        if (highs !== 100) begin
            n_fail++; $display("FAIL rst_mid_no_frame: TxD high %0d cycles required 100", highs);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_random_frames();
        test_overflow_back_to_back();
        test_irq();
        test_simul_push_pop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
